// File: rtl/addsub_arbiter.sv
// Round-robin arbiter that shares one add/subtract datapath between two requesters.
// Optional macro ADDSUB_ARB_FLAGS_EN adds resp_flags = {overflow, negative, zero}.
module addsub_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r0_sub,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic             r1_sub,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_sub,
  input  logic [WIDTH-1:0] dp_out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
`ifdef ADDSUB_ARB_FLAGS_EN
  output logic [2:0]       resp_flags,
`endif
  output logic [WIDTH-1:0] resp_data
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sub_q, sub_d;
  logic             gnt_q, gnt_d;
  logic             last_grant_q, last_grant_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             gnt_sel;

`ifdef ADDSUB_ARB_FLAGS_EN
  logic [2:0] flags_q, flags_d;
  logic       ovf;
  logic       a_msb, b_msb, r_msb;

  assign a_msb = a_q[WIDTH-1];
  assign b_msb = b_q[WIDTH-1];
  assign r_msb = dp_out[WIDTH-1];
  // Subtract overflows when signs differ; add overflows when they match.
  assign ovf   = (sub_q ? (a_msb != b_msb) : (a_msb == b_msb)) && (r_msb != a_msb);
  assign resp_flags = flags_q;
`endif

  assign dp_a       = a_q;
  assign dp_b       = b_q;
  assign dp_sub     = sub_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

  // On contention the requester that did not win last time is chosen.
  assign gnt_sel = (r0_valid && r1_valid) ? ~last_grant_q : r1_valid;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sub_d        = sub_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
`ifdef ADDSUB_ARB_FLAGS_EN
    flags_d      = flags_q;
`endif
    r0_ready     = 1'b0;
    r1_ready     = 1'b0;

    case (state_q)
      StIdle: begin
        if (r0_valid || r1_valid) begin
          r0_ready     = ~gnt_sel;
          r1_ready     = gnt_sel;
          a_d          = gnt_sel ? r1_a : r0_a;
          b_d          = gnt_sel ? r1_b : r0_b;
          sub_d        = gnt_sel ? r1_sub : r0_sub;
          gnt_d        = gnt_sel;
          last_grant_d = gnt_sel;
          state_d      = StExec;
        end
      end
      StExec: begin
        resp_data_d  = dp_out;
        resp_id_d    = gnt_q;
        resp_valid_d = 1'b1;
`ifdef ADDSUB_ARB_FLAGS_EN
        flags_d      = {ovf, dp_out[WIDTH-1], (dp_out == '0)};
`endif
        state_d      = StResp;
      end
      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
`ifdef ADDSUB_ARB_FLAGS_EN
      flags_q      <= 3'b000;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sub_q        <= sub_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
`ifdef ADDSUB_ARB_FLAGS_EN
      flags_q      <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter; supplies the shared add/sub datapath itself.
module tb_addsub_arbiter;
  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             r0_valid, r0_ready, r0_sub;
  logic [WIDTH-1:0] r0_a, r0_b;
  logic             r1_valid, r1_ready, r1_sub;
  logic [WIDTH-1:0] r1_a, r1_b;
  logic [WIDTH-1:0] dp_a, dp_b, dp_out;
  logic             dp_sub;
  logic             resp_valid, resp_ready, resp_id;
  logic [WIDTH-1:0] resp_data;
`ifdef ADDSUB_ARB_FLAGS_EN
  logic [2:0]       resp_flags;
`endif

  addsub_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r0_valid   (r0_valid),
    .r0_ready   (r0_ready),
    .r0_a       (r0_a),
    .r0_b       (r0_b),
    .r0_sub     (r0_sub),
    .r1_valid   (r1_valid),
    .r1_ready   (r1_ready),
    .r1_a       (r1_a),
    .r1_b       (r1_b),
    .r1_sub     (r1_sub),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_sub     (dp_sub),
    .dp_out     (dp_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
`ifdef ADDSUB_ARB_FLAGS_EN
    .resp_flags (resp_flags),
`endif
    .resp_data  (resp_data)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared arithmetic unit.
  assign dp_out = dp_sub ? (dp_a - dp_b) : (dp_a + dp_b);

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic [2:0]  flags;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   nassert = 0;
  int   nfail   = 0;
  int   nresp   = 0;
  int   npush   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nassert++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] d, input logic [2:0] f);
    sb.push_back('{id: id, data: d, flags: f});
    npush++;
  endtask

  // Monitor: compare each response at the cycle it is handed off.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        nassert++;
        nfail++;
        $display("FAIL unexpected_resp: got id %0d data %h, expected no response", resp_id,
                 resp_data);
      end else begin
        mon_e = sb.pop_front();
        check("resp_data", resp_data, mon_e.data);
        check("resp_id", 32'(resp_id), 32'(mon_e.id));
`ifdef ADDSUB_ARB_FLAGS_EN
        check("resp_flags", 32'(resp_flags), 32'(mon_e.flags));
`endif
        nresp++;
      end
    end
  end

  // Present an op, wait (bounded) for its ready, then drop valid just after the accept edge.
  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] ed, input logic [2:0] ef,
                       input bit do_push);
    bit ok = 1'b0;
    if (id) begin r1_valid = 1'b1; r1_a = a; r1_b = b; r1_sub = sub; end
    else    begin r0_valid = 1'b1; r0_a = a; r0_b = b; r0_sub = sub; end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = id ? r1_ready : r0_ready;
    end
    check("accept", 32'(ok), 32'd1);
    if (ok && do_push) push(id, ed, ef);
    @(posedge clk); #1;
    if (id) r1_valid = 1'b0;
    else    r0_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !resp_valid;
    end
    check("drain", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  logic [31:0] c0_a[2] = '{32'h8000_0000, 32'h0000_0003};
  logic [31:0] c0_b[2] = '{32'h0000_0001, 32'h0000_0004};
  logic        c0_s[2] = '{1'b1, 1'b0};
  logic [31:0] c0_r[2] = '{32'h7FFF_FFFF, 32'h0000_0007};
  logic [2:0]  c0_f[2] = '{3'b100, 3'b000};
  logic [31:0] c1_a[2] = '{32'h0000_FFFF, 32'h7FFF_FFFF};
  logic [31:0] c1_b[2] = '{32'h0000_0001, 32'h0000_0001};
  logic        c1_s[2] = '{1'b1, 1'b0};
  logic [31:0] c1_r[2] = '{32'h0000_FFFE, 32'h8000_0000};
  logic [2:0]  c1_f[2] = '{3'b000, 3'b110};

  initial begin
    int i0, i1, ng, g;
    int order[4];
    rst_n = 1'b0; resp_ready = 1'b1;
    r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_sub = 1'b0;
    r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_sub = 1'b0;

    // Reset and first grant
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    r0_valid = 1'b1; r0_a = 32'h2; r0_b = 32'h1; r0_sub = 1'b1;
    @(negedge clk);
    check("first_r0_ready", 32'(r0_ready), 32'd1);
    check("first_r1_ready", 32'(r1_ready), 32'd0);
    if (r0_ready) push(1'b0, 32'h1, 3'b000);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    @(negedge clk);
    check("lat_exec_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("lat_resp_valid", 32'(resp_valid), 32'd1);
    drain();

    // Wrap-around and mixed ops
    issue(1'b1, 32'h1234_5678, 32'h8765_4321, 1'b1, 32'h8ACF_1357, 3'b110, 1'b1);
    drain();
    issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 3'b001, 1'b1);
    drain();

    // Contention: both continuously valid for four ops
    i0 = 0; i1 = 0; ng = 0;
    r0_valid = 1'b1; r0_a = c0_a[0]; r0_b = c0_b[0]; r0_sub = c0_s[0];
    r1_valid = 1'b1; r1_a = c1_a[0]; r1_b = c1_b[0]; r1_sub = c1_s[0];
    for (int cyc = 0; cyc < 100 && (i0 < 2 || i1 < 2); cyc++) begin
      @(negedge clk);
      check("ready_excl", 32'(r0_ready & r1_ready), 32'd0);
      g = -1;
      if (r0_ready) g = 0;
      else if (r1_ready) g = 1;
      if (g >= 0 && ng < 4) begin
        order[ng] = g;
        ng++;
        if (g == 0) push(1'b0, c0_r[i0], c0_f[i0]);
        else        push(1'b1, c1_r[i1], c1_f[i1]);
      end
      @(posedge clk); #1;
      if (g == 0) begin
        i0++;
        if (i0 < 2) begin r0_a = c0_a[i0]; r0_b = c0_b[i0]; r0_sub = c0_s[i0]; end
        else r0_valid = 1'b0;
      end else if (g == 1) begin
        i1++;
        if (i1 < 2) begin r1_a = c1_a[i1]; r1_b = c1_b[i1]; r1_sub = c1_s[i1]; end
        else r1_valid = 1'b0;
      end
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    check("grant_count", 32'(ng), 32'd4);
    for (int k = 0; k < 4; k++) check("grant_order", 32'(order[k]), 32'(k % 2));
    drain();

    // Backpressure: response held for five cycles while r0 waits
    resp_ready = 1'b0;
    issue(1'b1, 32'h0000_0100, 32'h0000_0200, 1'b0, 32'h0000_0300, 3'b000, 1'b1);
    r0_valid = 1'b1; r0_a = 32'h5; r0_b = 32'h6; r0_sub = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_data", resp_data, 32'h0000_0300);
      check("bp_id", 32'(resp_id), 32'd1);
      check("bp_r0_ready", 32'(r0_ready), 32'd0);
      check("bp_r1_ready", 32'(r1_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_r0_ready", 32'(r0_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_next_grant", 32'(r0_ready), 32'd1);
    if (r0_ready) push(1'b0, 32'h0000_000B, 3'b000);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    drain();

    // Operand change right after the accept edge must not leak into the result
    issue(1'b0, 32'h1000_0000, 32'h0000_0001, 1'b1, 32'h0FFF_FFFF, 3'b000, 1'b1);
    r0_a = 32'h0;
    drain();

    // Reset while in EXEC: no response, and r0 wins the next contention
    issue(1'b0, 32'h7, 32'h7, 1'b0, 32'h0, 3'b000, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    r0_valid = 1'b1; r0_a = 32'h1; r0_b = 32'h2; r0_sub = 1'b0;
    r1_valid = 1'b1; r1_a = 32'h9; r1_b = 32'h4; r1_sub = 1'b1;
    @(negedge clk);
    check("postrst_valid", 32'(resp_valid), 32'd0);
    check("postrst_r0_ready", 32'(r0_ready), 32'd1);
    check("postrst_r1_ready", 32'(r1_ready), 32'd0);
    if (r0_ready) push(1'b0, 32'h3, 3'b000);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    issue(1'b1, 32'h9, 32'h4, 1'b1, 32'h5, 3'b000, 1'b1);
    drain();

    check("resp_count", 32'(nresp), 32'(npush));
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Arbiter and sequencer that shares one combinational 32-bit add/subtract datapath (the adder16-based subtractor/adder unit) between two requesters.
- Grants requesters round-robin and registers the operands that drive the shared unit.
- Captures the unit's result one cycle later and returns it over a common response channel with valid/ready flow control.
- Sits between the pipeline's address/ALU helper logic and the DSP-backed arithmetic unit, so only one datapath instance is needed.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- r0_valid  input  1  requester 0 has an operation pending.
- r0_ready  output  1  requester 0 operation accepted this cycle.
- r0_a  input  WIDTH  requester 0 operand A.
- r0_b  input  WIDTH  requester 0 operand B.
- r0_sub  input  1  requester 0 op: 1 = A-B, 0 = A+B.
- r1_valid  input  1  requester 1 has an operation pending.
- r1_ready  output  1  requester 1 operation accepted this cycle.
- r1_a  input  WIDTH  requester 1 operand A.
- r1_b  input  WIDTH  requester 1 operand B.
- r1_sub  input  1  requester 1 op select.
- dp_a  output  WIDTH  operand A to shared datapath.
- dp_b  output  WIDTH  operand B to shared datapath.
- dp_sub  output  1  add/subtract select to shared datapath.
- dp_out  input  WIDTH  combinational result from shared datapath.
- resp_valid  output  1  response holds a valid result.
- resp_ready  input  1  consumer accepts the response.
- resp_id  output  1  requester that issued the response (0/1).
- resp_data  output  WIDTH  result, modulo 2^WIDTH.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - Operand registers, dp_sub, resp_data and resp_id all 0; resp_valid=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Reset mid-operation abandons the operation with no response.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If exactly one rN_valid=1, grant that requester.
  - If both are valid, grant the requester != last_grant.
  - rN_ready=1 combinationally only for the granted requester, and only in IDLE.
  - On the grant edge: latch a/b/sub into the operand registers, set gnt_id, set last_grant=gnt_id, go to EXEC.
  - If no request is valid, stay in IDLE with both readys at 0.
- EXEC:
  - dp_a/dp_b/dp_sub are driven from the operand registers (they are driven from these registers in every state).
  - At the end of the cycle: resp_data<=dp_out, resp_id<=gnt_id, resp_valid<=1, go to RESP.
- RESP:
  - resp_valid, resp_data and resp_id are held stable until resp_ready=1.
  - On the handshake edge: resp_valid<=0, go to IDLE.
  - New requests are not accepted in RESP (both readys 0).
- Latency: accept at edge N, resp_valid=1 in the cycle after edge N+1. Best-case throughput is one op per 3 cycles when resp_ready is held at 1.
- Arithmetic wraps modulo 2^WIDTH; there is no saturation and no exception.
- Input changes:
  - Requester inputs are sampled only on the grant edge.
  - Later changes to rN_a, rN_b or rN_sub do not affect the result.
  - A valid that drops before grant is simply not served.
- Requester rules:
  - A requester must hold valid and operands stable until it sees ready.
  - The block never asserts both readys in the same cycle.
- Starvation freedom: with both requesters continuously valid, grants strictly alternate 0,1,0,1.

Optional Feature:
- Macro ADDSUB_ARB_FLAGS_EN.
- When defined:
  - Adds output resp_flags[2:0] = {overflow, negative, zero}, registered with resp_data in EXEC and held in RESP.
  - zero = (result==0); negative = result MSB.
  - Overflow for add: operands share a sign and the result sign differs.
  - Overflow for sub: operand signs differ and the result sign differs from A.
  - Reset value of resp_flags is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset and first grant: hold rst_n=0 for 2 cycles, then r0 sub 0x00000002-0x00000001 -> resp_valid=0 during reset; r0_ready in the first IDLE cycle; resp_valid 2 cycles after accept with resp_data=0x00000001, resp_id=0.
- Wrap-around and mixed ops: r1 sub 0x12345678-0x87654321 -> resp_data=0x8ACF1357; r1 add 0xFFFFFFFF+0x00000001 -> 0x00000000; with FLAGS_EN, the add gives flags=3'b001.
- Contention: r0 and r1 valid together for 4 ops -> grant order 0,1,0,1; r0 sub 0x80000000-1 -> 0x7FFFFFFF (flags 3'b100); r1 sub 0x0000FFFF-1 -> 0x0000FFFE.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_data/resp_id stable; both readys 0; no new accept until the handshake; next grant in the cycle after the handshake.
- Operand change after grant: change r0_a from 0x10000000 to 0 one cycle after accepting sub 0x10000000-1 -> resp_data=0x0FFFFFFF.
- Reset mid-operation: assert rst_n=0 while in EXEC -> no response is produced; the first request after reset is a contention and r0 is granted first.
